ahblite_slave_mux: RTL and testbench

- Data-phase response multiplexer for the AHB-Lite bus; sits directly downstream of the address decoder.
- Registers the decoder's P0..P4 select lines at each accepted address phase and routes the matching slave's HRDATA/HREADYOUT/HRESP back to the master during the following data phase.
- Contains the bus default slave: any active transfer that selects no port gets a two-cycle ERROR response.

---
 rtl/ahblite_slave_mux_if.sv | 35 +++
 rtl/ahblite_slave_mux.sv | 93 +++++++++
 tb/tb_ahblite_slave_mux.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahblite_slave_mux_if.sv
// AHB-Lite data-phase mux bus bundle.
// Groups the decoder selects, the per-slave responses and the muxed
// response back to the master. The slave modport is the mux's view;
// the master modport is the view of whatever drives the bus inputs.
interface ahblite_slave_mux_if;
  logic        HREADY;
  logic [1:0]  HTRANS;

  logic        P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL;
  logic        P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT, P4_HREADYOUT;
  logic        P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP;
  logic [31:0] P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P4_HRDATA;

  logic        HREADY_OUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HREADY, HTRANS,
    input  P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL,
    input  P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT, P4_HREADYOUT,
    input  P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP,
    input  P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P4_HRDATA,
    output HREADY_OUT, HRESP, HRDATA
  );

  modport master (
    output HREADY, HTRANS,
    output P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL,
    output P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT, P4_HREADYOUT,
    output P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP,
    output P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P4_HRDATA,
    input  HREADY_OUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase response multiplexer with built-in default slave.
// Ports:
//   HCLK    - bus clock, rising edge
//   HRESET  - asynchronous active-high reset
//   bus     - ahblite_slave_mux_if.slave: HREADY/HTRANS and P0..P4 selects
//             in, P0..P4 HREADYOUT/HRESP/HRDATA in, muxed HREADY_OUT/HRESP/
//             HRDATA out
// The address-phase select is captured on HREADY=1 edges and steers the
// following data phase. Unmapped active transfers get a two-cycle ERROR.
module ahblite_slave_mux #(
  parameter logic [31:0] DEF_RDATA    = 32'h0000_0000,
  parameter bit          DEF_SLAVE_EN = 1'b1
) (
  input logic                HCLK,
  input logic                HRESET,
  ahblite_slave_mux_if.slave bus
);
  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned SEL_W     = NUM_PORTS + 1;
  localparam int unsigned DEF_BIT   = NUM_PORTS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } def_state_t;

  logic [NUM_PORTS-1:0] hsel;
  logic [SEL_W-1:0]     sel_next;
  logic [SEL_W-1:0]     sel_q;
  def_state_t           def_state;

  assign hsel = {bus.P4_HSEL, bus.P3_HSEL, bus.P2_HSEL, bus.P1_HSEL, bus.P0_HSEL};

  // Priority-encode the decoder selects (lowest index wins) into one-hot.
  always_comb begin
    sel_next = '0;
    if (hsel[0])      sel_next[0] = 1'b1;
    else if (hsel[1]) sel_next[1] = 1'b1;
    else if (hsel[2]) sel_next[2] = 1'b1;
    else if (hsel[3]) sel_next[3] = 1'b1;
    else if (hsel[4]) sel_next[4] = 1'b1;
    else if (bus.HTRANS[1] && DEF_SLAVE_EN) sel_next[DEF_BIT] = 1'b1;
  end

  // Select register and default-slave FSM.
  // ERR1 holds HREADY_OUT low, so no capture can happen until ERR2.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_q     <= '0;
      def_state <= IDLE;
    end else begin
      if (bus.HREADY) sel_q <= sel_next;
      case (def_state)
        IDLE:    if (bus.HREADY && sel_next[DEF_BIT]) def_state <= ERR1;
        ERR1:    def_state <= ERR2;
        ERR2:    if (bus.HREADY) def_state <= sel_next[DEF_BIT] ? ERR1 : IDLE;
        default: def_state <= IDLE;
      endcase
    end
  end

  // Zero-latency response mux; nothing selected means zero-wait OKAY.
  always_comb begin
    bus.HREADY_OUT = 1'b1;
    bus.HRESP      = 1'b0;
    bus.HRDATA     = DEF_RDATA;
    if (sel_q[0]) begin
      bus.HREADY_OUT = bus.P0_HREADYOUT;
      bus.HRESP      = bus.P0_HRESP;
      bus.HRDATA     = bus.P0_HRDATA;
    end else if (sel_q[1]) begin
      bus.HREADY_OUT = bus.P1_HREADYOUT;
      bus.HRESP      = bus.P1_HRESP;
      bus.HRDATA     = bus.P1_HRDATA;
    end else if (sel_q[2]) begin
      bus.HREADY_OUT = bus.P2_HREADYOUT;
      bus.HRESP      = bus.P2_HRESP;
      bus.HRDATA     = bus.P2_HRDATA;
    end else if (sel_q[3]) begin
      bus.HREADY_OUT = bus.P3_HREADYOUT;
      bus.HRESP      = bus.P3_HRESP;
      bus.HRDATA     = bus.P3_HRDATA;
    end else if (sel_q[4]) begin
      bus.HREADY_OUT = bus.P4_HREADYOUT;
      bus.HRESP      = bus.P4_HRESP;
      bus.HRDATA     = bus.P4_HRDATA;
    end else if (sel_q[DEF_BIT]) begin
      bus.HREADY_OUT = (def_state != ERR1);
      bus.HRESP      = (def_state != IDLE);
    end
  end
endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Self-checking bench for ahblite_slave_mux: directed scenarios followed by
// random traffic, expected responses queued by the driver and checked by a
// separate monitor on the falling edge.
module tb_ahblite_slave_mux;
  localparam logic [31:0] DEF_RDATA = 32'h0000_0000;
  localparam bit          DEF_EN    = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahblite_slave_mux_if bus ();
  assign bus.HREADY = bus.HREADY_OUT;

  ahblite_slave_mux #(.DEF_RDATA(DEF_RDATA), .DEF_SLAVE_EN(DEF_EN)) dut (
    .HCLK  (clk),
    .HRESET(rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic        ready;
    logic        resp;
    logic [31:0] data;
    logic [15:0] idx;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_push = 0;

  // Stimulus for the current cycle.
  logic [4:0]  t_sel;
  logic [1:0]  t_trans;
  logic [4:0]  t_rdy;
  logic [4:0]  t_resp;
  logic [31:0] t_data [5];

  // Reference model: which target owns the data phase (-1 none, 0..4 port,
  // 5 default slave) and how many default-slave beats have elapsed.
  int m_bound = -1;
  int m_beat  = 0;

  task automatic apply();
    bus.HTRANS       = t_trans;
    bus.P0_HSEL      = t_sel[0];     bus.P1_HSEL      = t_sel[1];
    bus.P2_HSEL      = t_sel[2];     bus.P3_HSEL      = t_sel[3];
    bus.P4_HSEL      = t_sel[4];
    bus.P0_HREADYOUT = t_rdy[0];     bus.P1_HREADYOUT = t_rdy[1];
    bus.P2_HREADYOUT = t_rdy[2];     bus.P3_HREADYOUT = t_rdy[3];
    bus.P4_HREADYOUT = t_rdy[4];
    bus.P0_HRESP     = t_resp[0];    bus.P1_HRESP     = t_resp[1];
    bus.P2_HRESP     = t_resp[2];    bus.P3_HRESP     = t_resp[3];
    bus.P4_HRESP     = t_resp[4];
    bus.P0_HRDATA    = t_data[0];    bus.P1_HRDATA    = t_data[1];
    bus.P2_HRDATA    = t_data[2];    bus.P3_HRDATA    = t_data[3];
    bus.P4_HRDATA    = t_data[4];
  endtask

  task automatic set_in(input logic [4:0] sel, input logic [1:0] tr,
                        input logic [4:0] rdy, input logic [4:0] rsp);
    t_sel = sel; t_trans = tr; t_rdy = rdy; t_resp = rsp;
    for (int i = 0; i < 5; i++) t_data[i] = $urandom;
  endtask

  task automatic check_now(input string name, input logic r, input logic s,
                           input logic [31:0] d);
    n_vec++;
    if (bus.HREADY_OUT !== r || bus.HRESP !== s || bus.HRDATA !== d) begin
      n_fail++;
      $display("FAIL %s: got ready=%0b resp=%0b data=%h, want ready=%0b resp=%0b data=%h",
               name, bus.HREADY_OUT, bus.HRESP, bus.HRDATA, r, s, d);
    end
  endtask

  // One bus cycle: drive inputs after the edge, queue the expected response,
  // then advance the model across the next edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    apply();
    if (m_bound >= 0 && m_bound <= 4) begin
      e.ready = t_rdy[m_bound];
      e.resp  = t_resp[m_bound];
      e.data  = t_data[m_bound];
    end else if (m_bound == 5) begin
      e.ready = (m_beat == 1);
      e.resp  = 1'b1;
      e.data  = DEF_RDATA;
    end else begin
      e.ready = 1'b1;
      e.resp  = 1'b0;
      e.data  = DEF_RDATA;
    end
    e.idx = 16'(n_push);
    n_push++;
    sbq.push_back(e);
    if (m_bound == 5 && m_beat == 0) begin
      m_beat = 1;
    end else if (e.ready) begin
      m_bound = -1;
      for (int i = 4; i >= 0; i--) if (t_sel[i]) m_bound = i;
      if (m_bound == -1 && t_trans[1] && DEF_EN) begin
        m_bound = 5;
        m_beat  = 0;
      end
    end
  endtask

  // Monitor: compare each queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_vec++;
        if (bus.HREADY_OUT !== e.ready || bus.HRESP !== e.resp || bus.HRDATA !== e.data) begin
          n_fail++;
          $display("FAIL vec%0d: got ready=%0b resp=%0b data=%h, want ready=%0b resp=%0b data=%h",
                   e.idx, bus.HREADY_OUT, bus.HRESP, bus.HRDATA, e.ready, e.resp, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with random slave inputs
    set_in(5'($urandom), 2'($urandom), 5'($urandom), 5'($urandom));
    apply();
    #1 check_now("reset_0", 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(5'($urandom), 2'($urandom), 5'($urandom), 5'($urandom));
      apply();
      #1 check_now("reset_hold", 1'b1, 1'b0, 32'h0);
    end
    set_in(5'b0, 2'b00, 5'h1f, 5'h0);
    apply();
    @(negedge clk);
    rst = 1'b0;
    m_bound = -1;
    set_in(5'b0, 2'b00, 5'h1f, 5'h0); step();

    // P0 read; P1 data changes alongside without effect
    set_in(5'b00001, 2'b10, 5'h1f, 5'h0); step();
    set_in(5'b0, 2'b00, 5'h1f, 5'h0); t_data[0] = 32'h1234_5678; step();
    set_in(5'b0, 2'b00, 5'h1f, 5'h0); step();

    // P4 wait states while P1 is presented
    set_in(5'b10000, 2'b10, 5'h1f, 5'h0); step();
    for (int i = 0; i < 3; i++) begin
      set_in(5'b00010, 2'b10, 5'b01111, 5'h0); step();
    end
    set_in(5'b00010, 2'b10, 5'h1f, 5'h0); step();
    set_in(5'b0, 2'b00, 5'h1f, 5'h0); step();

    // Unmapped NONSEQ, then unmapped IDLE
    set_in(5'b0, 2'b10, 5'h1f, 5'h0); step();
    set_in(5'b0, 2'b00, 5'h1f, 5'h0); step();
    set_in(5'b0, 2'b00, 5'h1f, 5'h0); step();
    set_in(5'b0, 2'b00, 5'h1f, 5'h0); step();
    set_in(5'b0, 2'b00, 5'h1f, 5'h0); step();

    // Back-to-back unmapped SEQ beats, then a P1 transfer
    set_in(5'b0, 2'b11, 5'h1f, 5'h0); step();
    set_in(5'b0, 2'b11, 5'h1f, 5'h0); step();
    set_in(5'b0, 2'b11, 5'h1f, 5'h0); step();
    set_in(5'b0, 2'b11, 5'h1f, 5'h0); step();
    set_in(5'b00010, 2'b10, 5'h1f, 5'h0); step();
    set_in(5'b0, 2'b00, 5'h1f, 5'h0); step();

    // Reset asserted during ERR1
    set_in(5'b0, 2'b10, 5'h1f, 5'h0); step();
    @(posedge clk);
    #1 check_now("err1_pre_reset", 1'b0, 1'b1, DEF_RDATA);
    #2 rst = 1'b1;
    #1 check_now("reset_in_err1", 1'b1, 1'b0, DEF_RDATA);
    set_in(5'b0, 2'b00, 5'h1f, 5'h0);
    apply();
    @(posedge clk);
    #1 check_now("reset_held", 1'b1, 1'b0, DEF_RDATA);
    #2 rst = 1'b0;
    sbq.delete();
    m_bound = -1;
    set_in(5'b0, 2'b00, 5'h1f, 5'h0); step();
    set_in(5'b0, 2'b00, 5'h1f, 5'h0); step();

    // P0 and P2 together: P0 wins
    set_in(5'b00101, 2'b10, 5'h1f, 5'h0); step();
    set_in(5'b0, 2'b00, 5'h1f, 5'h0); step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] sel, rdy, rsp;
      for (int i = 0; i < 5; i++) begin
        sel[i] = ($urandom_range(0, 4) == 0);
        rdy[i] = ($urandom_range(0, 3) != 0);
        rsp[i] = ($urandom_range(0, 7) == 0);
      end
      set_in(sel, 2'($urandom), rdy, rsp);
      step();
    end

    @(posedge clk);
    @(posedge clk);
    n_vec++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
